// File: rtl/systolic_skew_feeder_if.sv
// Handshake and tile-facing bus of the systolic skew feeder.
// The master side (upstream source) drives the operands; the slave side is the feeder itself.
interface systolic_skew_feeder_if #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int KW     = 8
);
    logic                start;
    logic [KW-1:0]       k_len;
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] a_vec;
    logic [N*DATA_W-1:0] b_vec;
    logic [N*DATA_W-1:0] a_row_out;
    logic [N*DATA_W-1:0] b_col_out;
    logic                pe_en;
    logic                pe_clr;
    logic                busy;
    logic                done;

    modport master (
        output start, k_len, in_valid, a_vec, b_vec,
        input  in_ready, a_row_out, b_col_out, pe_en, pe_clr, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, a_vec, b_vec,
        output in_ready, a_row_out, b_col_out, pe_en, pe_clr, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Input staging for the 4x4 systolic tile: accepts K-slices, skews lane i by i cycles,
// and sequences clear / load / zero-flush / done for one matrix product.
module systolic_skew_feeder #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int KW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_skew_feeder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam int FLUSH_LEN = 2 * N - 1;
    localparam int FW        = $clog2(2 * N);

    state_t              state;
    logic [KW-1:0]       k_len_q;
    logic [KW-1:0]       beat_cnt;
    logic [FW-1:0]       flush_cnt;
    logic                advance;
    logic [N*DATA_W-1:0] head_a;
    logic [N*DATA_W-1:0] head_b;
    logic [N*DATA_W-1:0] a_row_w;
    logic [N*DATA_W-1:0] b_col_w;

    // Every skew register moves only on an advance, so the tile stalls as a whole.
    assign advance = (state == LOAD && bus.in_valid && bus.in_ready) || (state == FLUSH);
    assign head_a  = (state == LOAD) ? bus.a_vec : '0;
    assign head_b  = (state == LOAD) ? bus.b_vec : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k_len_q      <= '0;
            beat_cnt     <= '0;
            flush_cnt    <= '0;
            bus.in_ready <= 1'b0;
            bus.pe_en    <= 1'b0;
            bus.pe_clr   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.pe_en  <= advance;
            bus.pe_clr <= 1'b0;
            bus.done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.k_len != '0) begin
                            k_len_q      <= bus.k_len;
                            beat_cnt     <= '0;
                            bus.pe_clr   <= 1'b1;
                            bus.in_ready <= 1'b1;
                            state        <= LOAD;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                LOAD: begin
                    // Compare against k_len-1 so k_len = 2^KW-1 never needs a wider counter.
                    if (bus.in_valid) begin
                        if (beat_cnt == k_len_q - KW'(1)) begin
                            bus.in_ready <= 1'b0;
                            flush_cnt    <= '0;
                            state        <= FLUSH;
                        end else begin
                            beat_cnt <= beat_cnt + KW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane i is a chain of i+1 registers; the last one drives the tile directly.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] a_pipe [0:i];
        logic [DATA_W-1:0] b_pipe [0:i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    a_pipe[s] <= '0;
                    b_pipe[s] <= '0;
                end
            end else if (advance) begin
                a_pipe[0] <= head_a[i*DATA_W +: DATA_W];
                b_pipe[0] <= head_b[i*DATA_W +: DATA_W];
                for (int s = 1; s <= i; s++) begin
                    a_pipe[s] <= a_pipe[s-1];
                    b_pipe[s] <= b_pipe[s-1];
                end
            end
        end

        assign a_row_w[i*DATA_W +: DATA_W] = a_pipe[i];
        assign b_col_w[i*DATA_W +: DATA_W] = b_pipe[i];
    end

    assign bus.a_row_out = a_row_w;
    assign bus.b_col_out = b_col_w;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a history-based skew model, a tile model
// consuming the skewed streams, table-driven products and hand-written corner sequences.
module tb_systolic_skew_feeder;
    localparam int DATA_W = 8;
    localparam int N      = 4;
    localparam int KW     = 8;
    localparam int W      = N * DATA_W;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_FLUSH = 2, PH_DONE = 3;

    logic clk = 1'b0;
    logic rst;

    systolic_skew_feeder_if #(.DATA_W(DATA_W), .N(N), .KW(KW)) bus ();

    systolic_skew_feeder #(.DATA_W(DATA_W), .N(N), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: lane i shows the head value injected i advances ago.
    logic [W-1:0] hist_a [$];
    logic [W-1:0] hist_b [$];
    int           m_phase = PH_IDLE;
    int           m_left  = 0;
    int           m_flush = 0;
    logic         m_en    = 1'b0;
    logic         m_clr   = 1'b0;

    longint       acc   [N][N];
    logic [DATA_W-1:0] tile_a [N][N];
    logic [DATA_W-1:0] tile_b [N][N];

    typedef struct {
        int          k;
        logic [15:0] mask;
        int          latency;
        int          en_count;
        int          clr_count;
    } vec_t;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [W-1:0] skew_view(input logic [W-1:0] h [$]);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (i < h.size()) r[i*DATA_W +: DATA_W] = h[i][i*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic void model_clock(input logic r, input logic s, input logic [KW-1:0] k,
                                        input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        logic adv;
        if (r) begin
            m_phase = PH_IDLE;
            m_left  = 0;
            m_flush = 0;
            m_en    = 1'b0;
            m_clr   = 1'b0;
            hist_a.delete();
            hist_b.delete();
            return;
        end
        adv   = (m_phase == PH_LOAD && v) || m_phase == PH_FLUSH;
        m_en  = adv;
        m_clr = 1'b0;
        if (adv) begin
            hist_a.push_front(m_phase == PH_LOAD ? a : '0);
            hist_b.push_front(m_phase == PH_LOAD ? b : '0);
            if (hist_a.size() > N) begin
                void'(hist_a.pop_back());
                void'(hist_b.pop_back());
            end
        end
        case (m_phase)
            PH_IDLE: if (s) begin
                if (k != 0) begin
                    m_phase = PH_LOAD;
                    m_left  = int'(k);
                    m_clr   = 1'b1;
                end else begin
                    m_phase = PH_DONE;
                end
            end
            PH_LOAD: if (v) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = PH_FLUSH;
                    m_flush = 2 * N - 1;
                end
            end
            PH_FLUSH: begin
                m_flush--;
                if (m_flush == 0) m_phase = PH_DONE;
            end
            default: m_phase = PH_IDLE;
        endcase
    endfunction

    task automatic check_output();
        chk("in_ready",  64'(bus.in_ready),  64'(m_phase == PH_LOAD));
        chk("busy",      64'(bus.busy),      64'(m_phase != PH_IDLE));
        chk("done",      64'(bus.done),      64'(m_phase == PH_DONE));
        chk("pe_en",     64'(bus.pe_en),     64'(m_en));
        chk("pe_clr",    64'(bus.pe_clr),    64'(m_clr));
        chk("a_row_out", 64'(bus.a_row_out), 64'(skew_view(hist_a)));
        chk("b_col_out", 64'(bus.b_col_out), 64'(skew_view(hist_b)));
    endtask

    // Output-stationary tile fed by the DUT's skewed streams.
    task automatic tile_update();
        logic [DATA_W-1:0] na [N][N];
        logic [DATA_W-1:0] nb [N][N];
        if (rst || bus.pe_clr)
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) acc[i][j] = 0;
        if (bus.pe_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    na[i][j] = (j == 0) ? bus.a_row_out[i*DATA_W +: DATA_W] : tile_a[i][j-1];
                    nb[i][j] = (i == 0) ? bus.b_col_out[j*DATA_W +: DATA_W] : tile_b[i-1][j];
                    acc[i][j] += longint'(na[i][j]) * longint'(nb[i][j]);
                end
            tile_a = na;
            tile_b = nb;
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic [KW-1:0] k,
                                  input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        rst          = r;
        bus.start    = s;
        bus.k_len    = k;
        bus.in_valid = v;
        bus.a_vec    = a;
        bus.b_vec    = b;
        @(posedge clk);
        model_clock(r, s, k, v, a, b);
        @(negedge clk);
        cyc++;
        check_output();
        tile_update();
    endtask

    task automatic run_product(input int k, input logic [15:0] mask, input bit matrix, input int noise_k,
                               output int latency, output int en_count, output int clr_count,
                               output int done_count, output int max_run);
        int  beat, steps, run;
        bit  seen;
        logic v, s;
        logic [W-1:0] a, b;
        latency = 0; en_count = 0; clr_count = 0; done_count = 0; max_run = 0;
        beat = 0; run = 0; seen = 0; steps = 0;
        apply_stimulus(1'b0, 1'b1, KW'(k), 1'b0, '0, '0);
        while (!seen && steps < 600) begin
            if (bus.pe_en) begin run++; en_count++; end else run = 0;
            if (run > max_run) max_run = run;
            if (bus.pe_clr) clr_count++;
            if (bus.done) begin done_count++; seen = 1; latency = steps + 1; end
            if (!seen) begin
                v = (steps < 16) ? mask[steps] : 1'b1;
                s = (noise_k >= 0) && (m_phase == PH_LOAD);
                a = '0; b = '0;
                for (int i = 0; i < N; i++) begin
                    if (matrix) begin
                        a[i*DATA_W +: DATA_W] = DATA_W'(i * N + beat + 1);
                        b[i*DATA_W +: DATA_W] = DATA_W'(i == beat);
                    end else begin
                        a[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                        b[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                    end
                end
                if (m_phase == PH_LOAD && v) beat++;
                apply_stimulus(1'b0, s, (noise_k >= 0) ? KW'(noise_k) : '0, v, a, b);
                steps++;
            end
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
        if (bus.done) done_count++;
        chk("back_to_idle_busy", 64'(bus.busy), 64'(0));
    endtask

    vec_t vecs [6];
    int lat, enc, clrc, donec, maxr;

    initial begin
        vecs[0] = '{k: 1,   mask: 16'hFFFF, latency: 9,   en_count: 8,   clr_count: 1};
        vecs[1] = '{k: 4,   mask: 16'hFFFF, latency: 12,  en_count: 11,  clr_count: 1};
        vecs[2] = '{k: 0,   mask: 16'hFFFF, latency: 1,   en_count: 0,   clr_count: 0};
        vecs[3] = '{k: 3,   mask: 16'hFFE9, latency: 14,  en_count: 10,  clr_count: 1};
        vecs[4] = '{k: 2,   mask: 16'hFFFD, latency: 11,  en_count: 9,   clr_count: 1};
        vecs[5] = '{k: 255, mask: 16'hFFFF, latency: 263, en_count: 262, clr_count: 1};

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc[i][j] = 0; tile_a[i][j] = '0; tile_b[i][j] = '0;
            end

        rst = 1'b1; bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0; bus.a_vec = '0; bus.b_vec = '0;
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        apply_stimulus(1'b1, 1'b1, KW'(3), 1'b1, '1, '1);
        chk("reset_with_start_busy", 64'(bus.busy), 64'(0));
        chk("reset_a_row_out", 64'(bus.a_row_out), 64'(0));
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);

        // Skew timing: lane i of a single beat emerges i+1 cycles after acceptance.
        apply_stimulus(1'b0, 1'b1, KW'(1), 1'b0, '0, '0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 32'h04030201, '0);
        chk("skew_t1", 64'(bus.a_row_out), 64'h00000001);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("skew_t2", 64'(bus.a_row_out), 64'h00000200);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("skew_t3", 64'(bus.a_row_out), 64'h00030000);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
        chk("skew_t4", 64'(bus.a_row_out), 64'h04000000);
        for (int c = 5; c <= 8; c++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
            chk("skew_done_timing", 64'(bus.done), 64'(c == 8));
            chk("skew_zero_tail", 64'(bus.a_row_out), 64'(0));
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);

        // Full product against identity: the tile must reproduce A.
        run_product(4, 16'hFFFF, 1'b1, -1, lat, enc, clrc, donec, maxr);
        chk("full_pe_en_run", 64'(maxr), 64'(11));
        chk("full_done_count", 64'(donec), 64'(1));
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk("full_c_equals_a", 64'(acc[i][j]), 64'(i * N + j + 1));

        for (int t = 0; t < 6; t++) begin
            run_product(vecs[t].k, vecs[t].mask, 1'b0, -1, lat, enc, clrc, donec, maxr);
            chk("tbl_latency", 64'(lat), 64'(vecs[t].latency));
            chk("tbl_pe_en_count", 64'(enc), 64'(vecs[t].en_count));
            chk("tbl_pe_clr_count", 64'(clrc), 64'(vecs[t].clr_count));
            chk("tbl_done_count", 64'(donec), 64'(1));
        end

        // Reset mid-LOAD aborts without a done pulse.
        apply_stimulus(1'b0, 1'b1, KW'(4), 1'b0, '0, '0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 32'h11223344, 32'h55667788);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 32'h99AABBCC, 32'hDDEEFF01);
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, '0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b1, '0, '0);
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_outputs", 64'({bus.a_row_out, bus.b_col_out}), 64'(0));
        for (int c = 0; c < 10; c++) begin
            apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
            chk("midrst_no_done", 64'(bus.done), 64'(0));
        end
        run_product(2, 16'hFFFF, 1'b0, -1, lat, enc, clrc, donec, maxr);
        chk("post_rst_latency", 64'(lat), 64'(10));

        // start during LOAD with another k_len is ignored.
        run_product(3, 16'hFFFF, 1'b0, 7, lat, enc, clrc, donec, maxr);
        chk("ignored_start_latency", 64'(lat), 64'(11));
        chk("ignored_start_done", 64'(donec), 64'(1));

        for (int r = 0; r < 8; r++) begin
            run_product($urandom_range(1, 6), 16'($urandom), 1'b0, -1, lat, enc, clrc, donec, maxr);
            chk("rand_done_count", 64'(donec), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Input staging stage that sits directly upstream of the 4x4 hpe systolic tile.
- Accepts one K-slice per beat over a valid/ready handshake: N row operands (one A column) and N column operands (one B row).
- Applies diagonal skew: lane i is delayed i cycles, so operands meet in the correct PE. Drives the tile's row (a) and column (b) inputs plus its enable.
- Sequences one matrix product: clear, load k_len beats, zero-flush, then a done pulse.

Parameters:
- DATA_W, 8, operand width per lane
- N, 4, array dimension (number of row lanes and column lanes)
- KW, 8, width of the k_len input

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a product; sampled only in IDLE
- k_len  in  KW  number of K beats; latched when start is accepted
- in_valid  in  1  a_vec/b_vec valid
- in_ready  out  1  feeder accepts a beat this cycle
- a_vec  in  N*DATA_W  lane i = bits [i*DATA_W +: DATA_W], goes to row i
- b_vec  in  N*DATA_W  lane j goes to column j
- a_row_out  out  N*DATA_W  skewed row operands to tile a inputs
- b_col_out  out  N*DATA_W  skewed column operands to tile b inputs
- pe_en  out  1  tile advance enable
- pe_clr  out  1  one-cycle accumulator clear
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the product is complete in the tile

Behaviour:
- Reset: all outputs 0. All skew registers 0. State IDLE, counters 0.
  - Reset mid-operation aborts immediately. No done pulse is generated.
- Reset and start high together: reset wins.
- Skew structure: lane i (rows and columns alike) is a chain of i+1 registers, including the output register.
  - A lane-0 value accepted in cycle t appears on the output at t+1.
  - A lane-i value accepted in cycle t appears at t+1+i, provided every intermediate cycle advances.
- Advance: all skew registers shift together only in advance cycles. pe_en is registered and equals 1 in the cycle after each advance cycle.
  - Between advance cycles, outputs hold their values and pe_en = 0. The tile therefore stalls coherently.
- States:
  - IDLE: in_ready = 0.
    - start accepted with k_len != 0: latch k_len, pulse pe_clr the next cycle, go to LOAD.
    - start accepted with k_len = 0: go to DONE (no clear, no advance).
  - LOAD: in_ready = 1.
    - Advance cycle = in_valid & in_ready. New lane data enters the head of each chain.
    - in_valid low: no advance, no bubble injected.
    - The beat counter increments per accepted beat. After the k_len-th accept, go to FLUSH.
  - FLUSH: in_ready = 0.
    - Advances every cycle, injecting zeros at each chain head.
    - Lasts exactly 2N-1 cycles (7 for N=4), covering worst-case skew (N-1) plus propagation to the far PE (N-1) plus output register. Then go to DONE.
  - DONE: done = 1 for exactly one cycle, then return to IDLE. busy = 1 in DONE.
- pe_clr is asserted only in the cycle immediately after start is accepted. It never coincides with pe_en = 1.
- start outside IDLE is ignored. k_len is not re-sampled mid-operation.
- k_len = 2^KW - 1 must work: the counter is KW bits and has no wrap before the compare.
- Data passes through unmodified. There is no arithmetic; widths are preserved per lane.

Test Plan:
- Reset check: assert rst for 2 cycles mid-LOAD -> all outputs 0, busy 0, no done, next start behaves normally.
- Skew timing: start, k_len=1, a_vec lanes = {0x04,0x03,0x02,0x01} (lane0=0x01), in_valid constant -> lane0 row out = 0x01 at t+1, lane3 = 0x04 at t+4. Zeros on all other cycles. done 8 cycles after the accept cycle.
- Full product: k_len=4, A rows = 1..16, B = identity, 4 consecutive beats -> pe_en high for 11 consecutive cycles. A reference model of the tile yields C = A. Exactly one done pulse.
- Back-pressure: k_len=3, in_valid toggled 1,0,0,1,0,1 -> outputs freeze while in_valid is low, pe_en=0 on those cycles. Relative lane alignment is identical to the unstalled run.
- k_len=0: start -> done one cycle after accept, pe_clr never asserted, pe_en never asserted.
- start ignored: pulse start during LOAD with a different k_len -> original k_len beat count is honoured, single done.
